id_stage: RTL and testbench

Instruction-decode stage of the out-of-order MIPS32 core: a combinational decoder plus the ID→ROB pipeline register. It takes the fetched `pc`/`inst` and branch-prediction tags, drives register-file read requests, and produces one registered decoded micro-op per cycle for the ROB/issue stage. Operands still pending in the ROB are forwarded as references (`*_is_ref`), with `*_data` holding the ROB tag.

---
 rtl/id_stage.sv | 309 ++++++++++++++++++++++++++++++
 tb/tb_id_stage.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage.sv
// Instruction decode for the out-of-order MIPS32 core: combinational decoder
// feeding the ID->ROB pipeline register. Pending operands travel as ROB tags.
module id_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        stall_current_stage,
    input  logic        stall_next_stage,
    input  logic        is_branch_taken_in,
    input  logic [4:0]  pht_index_in,
    input  logic [31:0] pc_in,
    input  logic [31:0] inst_in,
    input  logic        reg_read_is_ref_1,
    input  logic        reg_read_is_ref_2,
    input  logic [31:0] reg_read_data_1,
    input  logic [31:0] reg_read_data_2,
    output logic        reg_read_en_1,
    output logic        reg_read_en_2,
    output logic [4:0]  reg_read_addr_1,
    output logic [4:0]  reg_read_addr_2,
    output logic        reg_write_en,
    output logic [4:0]  reg_write_addr,
    output logic        is_branch_taken_out,
    output logic [4:0]  pht_index_out,
    output logic        is_inst_branch,
    output logic        is_inst_jump,
    output logic        is_inst_branch_taken,
    output logic        is_inst_branch_determined,
    output logic [31:0] inst_branch_target,
    output logic        mem_write_flag,
    output logic        mem_read_flag,
    output logic        mem_sign_ext_flag,
    output logic [3:0]  mem_sel,
    output logic        mem_write_is_ref,
    output logic [31:0] mem_write_data,
    output logic [4:0]  cp0_addr,
    output logic        cp0_read_flag,
    output logic        cp0_write_flag,
    output logic        cp0_write_is_ref,
    output logic [31:0] cp0_write_data,
    output logic [2:0]  exception_type,
    output logic [5:0]  funct,
    output logic [4:0]  shamt,
    output logic        operand_is_ref_1,
    output logic        operand_is_ref_2,
    output logic [31:0] operand_data_1,
    output logic [31:0] operand_data_2,
    output logic [31:0] pc_out
);

    typedef struct packed {
        logic        rwe;
        logic [4:0]  rwa;
        logic        bt;
        logic [4:0]  pht;
        logic        br;
        logic        jmp;
        logic        tkn;
        logic        det;
        logic [31:0] tgt;
        logic        mw;
        logic        mr;
        logic        msx;
        logic [3:0]  msel;
        logic        mwref;
        logic [31:0] mwd;
        logic [4:0]  cp0a;
        logic        cp0r;
        logic        cp0w;
        logic        cp0wref;
        logic [31:0] cp0wd;
        logic [2:0]  exc;
        logic [5:0]  fn;
        logic [4:0]  sh;
        logic        oref1;
        logic        oref2;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] pc;
    } uop_t;

    uop_t uop_d, uop_q;
    logic en1, en2, rsv, br_cond;

    logic [5:0]  opcode, fn_f;
    logic [4:0]  rs, rt, rd;
    logic [31:0] pc4, pc8, imm_s, imm_z, br_off, d1, d2;

    assign opcode = inst_in[31:26];
    assign rs     = inst_in[25:21];
    assign rt     = inst_in[20:16];
    assign rd     = inst_in[15:11];
    assign fn_f   = inst_in[5:0];
    assign pc4    = pc_in + 32'd4;
    assign pc8    = pc_in + 32'd8;
    assign imm_s  = {{16{inst_in[15]}}, inst_in[15:0]};
    assign imm_z  = {16'h0000, inst_in[15:0]};
    assign br_off = {{14{inst_in[15]}}, inst_in[15:0], 2'b00};
    assign d1     = reg_read_data_1;
    assign d2     = reg_read_data_2;

    always_comb begin
        uop_d   = '0;
        en1     = 1'b0;
        en2     = 1'b0;
        rsv     = 1'b0;
        br_cond = 1'b0;
        uop_d.pc  = pc_in;
        uop_d.bt  = is_branch_taken_in;
        uop_d.pht = pht_index_in;
        case (opcode)
            6'h00: begin
                if (fn_f inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, [6'h10:6'h13],
                                 [6'h18:6'h1B], [6'h20:6'h27], 6'h2A, 6'h2B}) begin
                    en1 = !(fn_f inside {6'h00, 6'h02, 6'h03});
                    en2 = 1'b1;
                    uop_d.fn = fn_f;
                    uop_d.sh = inst_in[10:6];
                    uop_d.op1 = d1;
                    uop_d.oref1 = reg_read_is_ref_1;
                    uop_d.op2 = d2;
                    uop_d.oref2 = reg_read_is_ref_2;
                    uop_d.rwe = 1'b1;
                    uop_d.rwa = rd;
                end else if (fn_f inside {6'h08, 6'h09}) begin
                    en1 = 1'b1;
                    uop_d.jmp = 1'b1;
                    uop_d.tkn = 1'b1;
                    uop_d.det = !reg_read_is_ref_1;
                    uop_d.tgt = reg_read_is_ref_1 ? 32'd0 : d1;
                    if (fn_f == 6'h09) begin
                        // Link: the ALU computes pc+8 + 0 into rd.
                        uop_d.fn = 6'h21;
                        uop_d.op1 = pc8;
                        uop_d.rwe = 1'b1;
                        uop_d.rwa = rd;
                    end else begin
                        uop_d.fn = fn_f;
                        uop_d.op1 = d1;
                        uop_d.oref1 = reg_read_is_ref_1;
                    end
                end else if (fn_f == 6'h0C) begin
                    uop_d.exc = 3'd1;
                end else if (fn_f == 6'h0D) begin
                    uop_d.exc = 3'd2;
                end else begin
                    rsv = 1'b1;
                end
            end
            6'h02, 6'h03: begin
                uop_d.br = 1'b1;
                uop_d.jmp = 1'b1;
                uop_d.tkn = 1'b1;
                uop_d.det = 1'b1;
                uop_d.tgt = {pc4[31:28], inst_in[25:0], 2'b00};
                if (opcode == 6'h03) begin
                    uop_d.fn = 6'h21;
                    uop_d.op1 = pc8;
                    uop_d.rwe = 1'b1;
                    uop_d.rwa = 5'd31;
                end
            end
            6'h01, 6'h04, 6'h05, 6'h06, 6'h07: begin
                uop_d.br = 1'b1;
                uop_d.tgt = pc4 + br_off;
                en1 = 1'b1;
                uop_d.op1 = d1;
                uop_d.oref1 = reg_read_is_ref_1;
                if (opcode inside {6'h04, 6'h05}) begin
                    en2 = 1'b1;
                    uop_d.op2 = d2;
                    uop_d.oref2 = reg_read_is_ref_2;
                end
                uop_d.det = !reg_read_is_ref_1 && !(en2 && reg_read_is_ref_2);
                case (opcode)
                    6'h01: begin
                        br_cond = (rt == 5'd0) ? d1[31] : !d1[31];
                        rsv = (rt[4:1] != 4'd0);
                    end
                    6'h04:   br_cond = (d1 == d2);
                    6'h05:   br_cond = (d1 != d2);
                    6'h06:   br_cond = d1[31] || (d1 == 32'd0);
                    default: br_cond = !d1[31] && (d1 != 32'd0);
                endcase
                uop_d.tkn = uop_d.det && br_cond;
            end
            6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E: begin
                en1 = 1'b1;
                uop_d.op1 = d1;
                uop_d.oref1 = reg_read_is_ref_1;
                uop_d.op2 = (opcode >= 6'h0C) ? imm_z : imm_s;
                uop_d.rwe = 1'b1;
                uop_d.rwa = rt;
                case (opcode)
                    6'h08:   uop_d.fn = 6'h20;
                    6'h09:   uop_d.fn = 6'h21;
                    6'h0A:   uop_d.fn = 6'h2A;
                    6'h0B:   uop_d.fn = 6'h2B;
                    6'h0C:   uop_d.fn = 6'h24;
                    6'h0D:   uop_d.fn = 6'h25;
                    default: uop_d.fn = 6'h26;
                endcase
            end
            6'h0F: begin
                uop_d.fn = 6'h25;
                uop_d.op2 = {inst_in[15:0], 16'h0000};
                uop_d.rwe = 1'b1;
                uop_d.rwa = rt;
            end
            6'h10: begin
                if (inst_in == 32'h4200_0018) begin
                    uop_d.exc = 3'd3;
                end else if (rs == 5'd0) begin
                    uop_d.cp0r = 1'b1;
                    uop_d.cp0a = rd;
                    uop_d.rwe = 1'b1;
                    uop_d.rwa = rt;
                end else if (rs == 5'd4) begin
                    en2 = 1'b1;
                    uop_d.cp0w = 1'b1;
                    uop_d.cp0a = rd;
                    uop_d.cp0wd = d2;
                    uop_d.cp0wref = reg_read_is_ref_2;
                end else begin
                    rsv = 1'b1;
                end
            end
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B: begin
                // Address generation goes through the ALU as rs + sext(imm).
                en1 = 1'b1;
                uop_d.fn = 6'h21;
                uop_d.op1 = d1;
                uop_d.oref1 = reg_read_is_ref_1;
                uop_d.op2 = imm_s;
                uop_d.msel = (opcode[1:0] == 2'b00) ? 4'b0001 :
                             (opcode[1:0] == 2'b01) ? 4'b0011 : 4'b1111;
                if (opcode[3]) begin
                    en2 = 1'b1;
                    uop_d.mw = 1'b1;
                    uop_d.mwd = d2;
                    uop_d.mwref = reg_read_is_ref_2;
                end else begin
                    uop_d.mr = 1'b1;
                    uop_d.msx = !opcode[2];
                    uop_d.rwe = 1'b1;
                    uop_d.rwa = rt;
                end
            end
            default: rsv = 1'b1;
        endcase
        if (rsv) begin
            uop_d     = '0;
            uop_d.pc  = pc_in;
            uop_d.bt  = is_branch_taken_in;
            uop_d.pht = pht_index_in;
            uop_d.exc = 3'd4;
            en1 = 1'b0;
            en2 = 1'b0;
        end
        if (uop_d.rwa == 5'd0) uop_d.rwe = 1'b0;
        if (rst) begin
            uop_d = '0;
            en1 = 1'b0;
            en2 = 1'b0;
        end
    end

    assign reg_read_en_1   = en1;
    assign reg_read_en_2   = en2;
    assign reg_read_addr_1 = rst ? 5'd0 : rs;
    assign reg_read_addr_2 = rst ? 5'd0 : rt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                            uop_q <= '0;
        else if (flush)                                     uop_q <= '0;
        else if (stall_current_stage && !stall_next_stage)  uop_q <= '0;
        else if (!stall_current_stage)                      uop_q <= uop_d;
    end

    assign reg_write_en              = uop_q.rwe;
    assign reg_write_addr            = uop_q.rwa;
    assign is_branch_taken_out       = uop_q.bt;
    assign pht_index_out             = uop_q.pht;
    assign is_inst_branch            = uop_q.br;
    assign is_inst_jump              = uop_q.jmp;
    assign is_inst_branch_taken      = uop_q.tkn;
    assign is_inst_branch_determined = uop_q.det;
    assign inst_branch_target        = uop_q.tgt;
    assign mem_write_flag            = uop_q.mw;
    assign mem_read_flag             = uop_q.mr;
    assign mem_sign_ext_flag         = uop_q.msx;
    assign mem_sel                   = uop_q.msel;
    assign mem_write_is_ref          = uop_q.mwref;
    assign mem_write_data            = uop_q.mwd;
    assign cp0_addr                  = uop_q.cp0a;
    assign cp0_read_flag             = uop_q.cp0r;
    assign cp0_write_flag            = uop_q.cp0w;
    assign cp0_write_is_ref          = uop_q.cp0wref;
    assign cp0_write_data            = uop_q.cp0wd;
    assign exception_type            = uop_q.exc;
    assign funct                     = uop_q.fn;
    assign shamt                     = uop_q.sh;
    assign operand_is_ref_1          = uop_q.oref1;
    assign operand_is_ref_2          = uop_q.oref2;
    assign operand_data_1            = uop_q.op1;
    assign operand_data_2            = uop_q.op2;
    assign pc_out                    = uop_q.pc;

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: table of hand-decoded instructions plus flush, stall,
// hold and asynchronous reset sequences, checked through an expected queue.
module tb_id_stage;

    typedef struct packed {
        logic        rwe;
        logic [4:0]  rwa;
        logic        bt;
        logic [4:0]  pht;
        logic        br, jmp, tkn, det;
        logic [31:0] tgt;
        logic        mw, mr, msx;
        logic [3:0]  msel;
        logic        mwref;
        logic [31:0] mwd;
        logic [4:0]  cp0a;
        logic        cp0r, cp0w, cp0wref;
        logic [31:0] cp0wd;
        logic [2:0]  exc;
        logic [5:0]  fn;
        logic [4:0]  sh;
        logic        oref1, oref2;
        logic [31:0] op1, op2, pc;
    } out_t;

    localparam int OW = $bits(out_t);
    localparam logic [31:0] D1 = 32'h1234_5678;
    localparam logic [31:0] D2 = 32'hABCD_EF00;

    typedef struct {
        logic [31:0] pc, inst;
        logic        ref1, ref2, bt;
        logic [4:0]  pht;
        logic        en1, en2;
        logic [4:0]  a1, a2;
        out_t        exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst, flush, stall_current_stage, stall_next_stage;
    logic        is_branch_taken_in;
    logic [4:0]  pht_index_in;
    logic [31:0] pc_in, inst_in;
    logic        reg_read_is_ref_1, reg_read_is_ref_2;
    logic [31:0] reg_read_data_1, reg_read_data_2;
    logic        reg_read_en_1, reg_read_en_2;
    logic [4:0]  reg_read_addr_1, reg_read_addr_2;
    logic        reg_write_en;
    logic [4:0]  reg_write_addr;
    logic        is_branch_taken_out;
    logic [4:0]  pht_index_out;
    logic        is_inst_branch, is_inst_jump, is_inst_branch_taken, is_inst_branch_determined;
    logic [31:0] inst_branch_target;
    logic        mem_write_flag, mem_read_flag, mem_sign_ext_flag;
    logic [3:0]  mem_sel;
    logic        mem_write_is_ref;
    logic [31:0] mem_write_data;
    logic [4:0]  cp0_addr;
    logic        cp0_read_flag, cp0_write_flag, cp0_write_is_ref;
    logic [31:0] cp0_write_data;
    logic [2:0]  exception_type;
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic        operand_is_ref_1, operand_is_ref_2;
    logic [31:0] operand_data_1, operand_data_2, pc_out;

    id_stage dut (
        .clk(clk), .rst(rst), .flush(flush),
        .stall_current_stage(stall_current_stage), .stall_next_stage(stall_next_stage),
        .is_branch_taken_in(is_branch_taken_in), .pht_index_in(pht_index_in),
        .pc_in(pc_in), .inst_in(inst_in),
        .reg_read_is_ref_1(reg_read_is_ref_1), .reg_read_is_ref_2(reg_read_is_ref_2),
        .reg_read_data_1(reg_read_data_1), .reg_read_data_2(reg_read_data_2),
        .reg_read_en_1(reg_read_en_1), .reg_read_en_2(reg_read_en_2),
        .reg_read_addr_1(reg_read_addr_1), .reg_read_addr_2(reg_read_addr_2),
        .reg_write_en(reg_write_en), .reg_write_addr(reg_write_addr),
        .is_branch_taken_out(is_branch_taken_out), .pht_index_out(pht_index_out),
        .is_inst_branch(is_inst_branch), .is_inst_jump(is_inst_jump),
        .is_inst_branch_taken(is_inst_branch_taken),
        .is_inst_branch_determined(is_inst_branch_determined),
        .inst_branch_target(inst_branch_target),
        .mem_write_flag(mem_write_flag), .mem_read_flag(mem_read_flag),
        .mem_sign_ext_flag(mem_sign_ext_flag), .mem_sel(mem_sel),
        .mem_write_is_ref(mem_write_is_ref), .mem_write_data(mem_write_data),
        .cp0_addr(cp0_addr), .cp0_read_flag(cp0_read_flag), .cp0_write_flag(cp0_write_flag),
        .cp0_write_is_ref(cp0_write_is_ref), .cp0_write_data(cp0_write_data),
        .exception_type(exception_type), .funct(funct), .shamt(shamt),
        .operand_is_ref_1(operand_is_ref_1), .operand_is_ref_2(operand_is_ref_2),
        .operand_data_1(operand_data_1), .operand_data_2(operand_data_2),
        .pc_out(pc_out)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int n_cmp = 0;
    int n_bad = 0;
    logic [OW-1:0] exp_q[$];
    vec_t tbl[$];
    vec_t v_addiu, v_ori;

    function automatic out_t sample();
        out_t s;
        s.rwe = reg_write_en;          s.rwa = reg_write_addr;
        s.bt = is_branch_taken_out;    s.pht = pht_index_out;
        s.br = is_inst_branch;         s.jmp = is_inst_jump;
        s.tkn = is_inst_branch_taken;  s.det = is_inst_branch_determined;
        s.tgt = inst_branch_target;
        s.mw = mem_write_flag;         s.mr = mem_read_flag;
        s.msx = mem_sign_ext_flag;     s.msel = mem_sel;
        s.mwref = mem_write_is_ref;    s.mwd = mem_write_data;
        s.cp0a = cp0_addr;             s.cp0r = cp0_read_flag;
        s.cp0w = cp0_write_flag;       s.cp0wref = cp0_write_is_ref;
        s.cp0wd = cp0_write_data;      s.exc = exception_type;
        s.fn = funct;                  s.sh = shamt;
        s.oref1 = operand_is_ref_1;    s.oref2 = operand_is_ref_2;
        s.op1 = operand_data_1;        s.op2 = operand_data_2;
        s.pc = pc_out;
        return s;
    endfunction

    function automatic vec_t base(input logic [31:0] pc, input logic [31:0] inst);
        vec_t v;
        v.pc = pc;     v.inst = inst;
        v.ref1 = 1'b0; v.ref2 = 1'b0; v.bt = 1'b0; v.pht = 5'd0;
        v.en1 = 1'b0;  v.en2 = 1'b0;
        v.a1 = inst[25:21];
        v.a2 = inst[20:16];
        v.exp = '0;
        v.exp.pc = pc;
        return v;
    endfunction

    task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // driver tasks
    task automatic drive(input vec_t v);
        pc_in = v.pc;
        inst_in = v.inst;
        reg_read_is_ref_1 = v.ref1;
        reg_read_is_ref_2 = v.ref2;
        is_branch_taken_in = v.bt;
        pht_index_in = v.pht;
    endtask

    task automatic pop_check(input string name);
        logic [OW-1:0] e;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: expected queue empty", name);
        end else begin
            e = exp_q.pop_front();
            check(name, OW'(sample()), e);
        end
    endtask

    task automatic apply(input vec_t v, input string name);
        @(negedge clk);
        drive(v);
        #1;
        n_cmp++;
        if ({reg_read_en_1, reg_read_en_2, reg_read_addr_1, reg_read_addr_2} !==
            {v.en1, v.en2, v.a1, v.a2}) begin
            n_bad++;
            $display("FAIL %s_rdreq: got en=%b%b a1=%0d a2=%0d expected en=%b%b a1=%0d a2=%0d",
                     name, reg_read_en_1, reg_read_en_2, reg_read_addr_1, reg_read_addr_2,
                     v.en1, v.en2, v.a1, v.a2);
        end
        exp_q.push_back(v.exp);
        @(posedge clk);
        #1;
        pop_check(name);
    endtask

    task automatic build_table();
        vec_t v;
        v = base(32'hBFC0_0000, 32'h9000_1234); v.bt = 1'b1; v.pht = 5'h15; v.en1 = 1'b1;
        v.exp.bt = 1'b1; v.exp.pht = 5'h15; v.exp.mr = 1'b1; v.exp.msel = 4'b0001;
        v.exp.fn = 6'h21; v.exp.op1 = D1; v.exp.op2 = 32'h0000_1234; tbl.push_back(v);
        v = base(32'hBFC0_0004, 32'hAC00_1234); v.en1 = 1'b1; v.en2 = 1'b1;
        v.exp.mw = 1'b1; v.exp.msel = 4'b1111; v.exp.mwd = D2; v.exp.fn = 6'h21;
        v.exp.op1 = D1; v.exp.op2 = 32'h0000_1234; tbl.push_back(v);
        v = base(32'hBFC0_0008, 32'h0C12_3456);
        v.exp.rwe = 1'b1; v.exp.rwa = 5'd31; v.exp.br = 1'b1; v.exp.jmp = 1'b1;
        v.exp.tkn = 1'b1; v.exp.det = 1'b1; v.exp.tgt = 32'hB048_D158;
        v.exp.fn = 6'h21; v.exp.op1 = 32'hBFC0_0010; tbl.push_back(v);
        v = base(32'hBFC0_0010, 32'h1400_1234); v.en1 = 1'b1; v.en2 = 1'b1;
        v.exp.br = 1'b1; v.exp.det = 1'b1; v.exp.tkn = 1'b1; v.exp.tgt = 32'hBFC0_48E4;
        v.exp.op1 = D1; v.exp.op2 = D2; tbl.push_back(v);
        v.ref1 = 1'b1; v.exp.det = 1'b0; v.exp.tkn = 1'b0; v.exp.oref1 = 1'b1; tbl.push_back(v);
        v = base(32'hBFC0_0018, 32'h2408_CDEF); v.en1 = 1'b1;
        v.exp.rwe = 1'b1; v.exp.rwa = 5'd8; v.exp.fn = 6'h21; v.exp.op1 = D1;
        v.exp.op2 = 32'hFFFF_CDEF; tbl.push_back(v); v_addiu = v;
        v = base(32'hBFC0_001C, 32'h2000_CDEF); v.en1 = 1'b1;
        v.exp.fn = 6'h20; v.exp.op1 = D1; v.exp.op2 = 32'hFFFF_CDEF; tbl.push_back(v);
        v = base(32'hBFC0_0020, 32'hFFFF_FFFF); v.exp.exc = 3'd4; tbl.push_back(v);
        v = base(32'hBFC0_0024, 32'h0085_1021); v.ref2 = 1'b1; v.en1 = 1'b1; v.en2 = 1'b1;
        v.exp.rwe = 1'b1; v.exp.rwa = 5'd2; v.exp.fn = 6'h21; v.exp.op1 = D1;
        v.exp.op2 = D2; v.exp.oref2 = 1'b1; tbl.push_back(v);
        v = base(32'hBFC0_0028, 32'h0005_19C0); v.en2 = 1'b1;
        v.exp.rwe = 1'b1; v.exp.rwa = 5'd3; v.exp.sh = 5'd7; v.exp.op1 = D1;
        v.exp.op2 = D2; tbl.push_back(v);
        v = base(32'hBFC0_002C, 32'h3429_8001); v.en1 = 1'b1;
        v.exp.rwe = 1'b1; v.exp.rwa = 5'd9; v.exp.fn = 6'h25; v.exp.op1 = D1;
        v.exp.op2 = 32'h0000_8001; tbl.push_back(v); v_ori = v;
        v = base(32'hBFC0_0030, 32'h3C04_BEEF);
        v.exp.rwe = 1'b1; v.exp.rwa = 5'd4; v.exp.fn = 6'h25; v.exp.op2 = 32'hBEEF_0000;
        tbl.push_back(v);
        v = base(32'hBFC0_0034, 32'h84E6_FFFC); v.en1 = 1'b1;
        v.exp.mr = 1'b1; v.exp.msx = 1'b1; v.exp.msel = 4'b0011; v.exp.rwe = 1'b1;
        v.exp.rwa = 5'd6; v.exp.fn = 6'h21; v.exp.op1 = D1; v.exp.op2 = 32'hFFFF_FFFC;
        tbl.push_back(v);
        v = base(32'hBFC0_0040, 32'h1022_FFFF); v.en1 = 1'b1; v.en2 = 1'b1;
        v.exp.br = 1'b1; v.exp.det = 1'b1; v.exp.tgt = 32'hBFC0_0040;
        v.exp.op1 = D1; v.exp.op2 = D2; tbl.push_back(v);
        v = base(32'hBFC0_0050, 32'h0461_0010); v.ref2 = 1'b1; v.en1 = 1'b1;
        v.exp.br = 1'b1; v.exp.det = 1'b1; v.exp.tkn = 1'b1; v.exp.tgt = 32'hBFC0_0094;
        v.exp.op1 = D1; tbl.push_back(v);
        v = base(32'hBFC0_0058, 32'h03E0_0008); v.en1 = 1'b1;
        v.exp.jmp = 1'b1; v.exp.tkn = 1'b1; v.exp.det = 1'b1; v.exp.tgt = D1;
        v.exp.fn = 6'h08; v.exp.op1 = D1; tbl.push_back(v);
        v.pc = 32'hBFC0_005C; v.exp.pc = 32'hBFC0_005C; v.ref1 = 1'b1;
        v.exp.det = 1'b0; v.exp.tgt = 32'd0; v.exp.oref1 = 1'b1; tbl.push_back(v);
        v = base(32'hBFC0_0060, 32'h0080_2809); v.en1 = 1'b1;
        v.exp.jmp = 1'b1; v.exp.tkn = 1'b1; v.exp.det = 1'b1; v.exp.tgt = D1;
        v.exp.rwe = 1'b1; v.exp.rwa = 5'd5; v.exp.fn = 6'h21; v.exp.op1 = 32'hBFC0_0068;
        tbl.push_back(v);
        v = base(32'hBFC0_0064, 32'h4007_6000);
        v.exp.cp0r = 1'b1; v.exp.cp0a = 5'd12; v.exp.rwe = 1'b1; v.exp.rwa = 5'd7;
        tbl.push_back(v);
        v = base(32'hBFC0_0068, 32'h4088_7000); v.ref2 = 1'b1; v.en2 = 1'b1;
        v.exp.cp0w = 1'b1; v.exp.cp0a = 5'd14; v.exp.cp0wd = D2; v.exp.cp0wref = 1'b1;
        tbl.push_back(v);
        v = base(32'hBFC0_006C, 32'h0000_000C); v.exp.exc = 3'd1; tbl.push_back(v);
        v = base(32'hBFC0_0070, 32'h4200_0018); v.exp.exc = 3'd3; tbl.push_back(v);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; stall_current_stage = 1'b0; stall_next_stage = 1'b0;
        reg_read_data_1 = D1; reg_read_data_2 = D2;
        build_table();
        drive(v_addiu);
        #3;
        check("reset_outputs", OW'(sample()), '0);
        check("reset_rdreq", OW'({reg_read_en_1, reg_read_en_2, reg_read_addr_1, reg_read_addr_2}), '0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

        apply(v_addiu, "flush_load");
        @(negedge clk); drive(v_ori); flush = 1'b1; exp_q.push_back('0);
        @(posedge clk); #1; pop_check("flush");
        @(negedge clk); flush = 1'b0;

        apply(v_addiu, "bubble_load");
        @(negedge clk); drive(v_ori); stall_current_stage = 1'b1; exp_q.push_back('0);
        @(posedge clk); #1; pop_check("bubble");
        @(negedge clk); stall_current_stage = 1'b0;

        apply(v_addiu, "hold_load");
        @(negedge clk); drive(v_ori); stall_current_stage = 1'b1; stall_next_stage = 1'b1;
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back(v_addiu.exp);
            @(posedge clk); #1; pop_check($sformatf("hold%0d", k));
        end
        @(negedge clk); flush = 1'b1; exp_q.push_back('0);
        @(posedge clk); #1; pop_check("flush_over_stall");
        @(negedge clk); flush = 1'b0; stall_current_stage = 1'b0; stall_next_stage = 1'b0;

        apply(v_addiu, "arst_load");
        @(negedge clk); #2; rst = 1'b1; #1;
        check("arst_outputs", OW'(sample()), '0);
        check("arst_rdreq", OW'({reg_read_en_1, reg_read_en_2}), '0);
        @(negedge clk); rst = 1'b0;
        apply(v_ori, "after_arst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
